// File: rtl/elem_unary_seq_if.sv
// Common fixed-point port bundle: clock, synchronous reset and the data width.
interface fixedp #(
  parameter int unsigned WIDTH = 16
) ();
  logic clk;
  logic reset;

  modport master (output clk, output reset);
  modport slave  (input  clk, input  reset);
endinterface

// File: rtl/elem_unary_seq.sv
// Element-by-element unary operator (pass / neg / abs / -abs) on a ROWS x COLS
// fixed-point matrix, LANES elements per clock, start/busy/done handshake.
module elem_unary_seq #(
  parameter int unsigned ROWS  = 1,
  parameter int unsigned COLS  = 1,
  parameter int unsigned LANES = 1,
  parameter int unsigned SAT   = 1,
  parameter int unsigned W     = 16   // element width; keep equal to g.WIDTH
) (
  fixedp.slave                           g,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [ROWS:1][COLS:1][W-1:0]   a,
  output logic [ROWS:1][COLS:1][W-1:0]   f,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = $clog2(N + LANES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_V = ~MIN_V;

  logic [0:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           beat_end;
  logic [1:0]              mode_q, mode_d;
  logic [N-1:0][W-1:0]     a_flat;
  logic [N-1:0][W-1:0]     a_q, a_d;
  logic [N-1:0][W-1:0]     f_q, f_d;
  logic                    busy_d, done_d;

  // Row-major flattening of the operand and result matrices.
  for (genvar r = 1; r <= int'(ROWS); r++) begin : g_row
    for (genvar c = 1; c <= int'(COLS); c++) begin : g_col
      assign a_flat[(r-1)*int'(COLS) + (c-1)] = a[r][c];
      assign f[r][c] = f_q[(r-1)*int'(COLS) + (c-1)];
    end
  end

  // One element through the selected operator; MIN under neg/abs is the only overflow.
  function automatic logic [W-1:0] apply_op(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] neg;
    logic [W-1:0] r;
    neg = -x;
    case (m)
      2'd0:    r = x;
      2'd1:    r = neg;
      2'd2:    r = x[W-1] ? neg : x;
      default: r = x[W-1] ? x : neg;
    endcase
    if ((SAT != 0) && (x == MIN_V) && ((m == 2'd1) || (m == 2'd2)))
      r = MAX_V;
    return r;
  endfunction

  // Next-state and datapath: snapshot on start, then LANES elements per beat.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    a_d      = a_q;
    f_d      = f_q;
    busy_d   = busy;
    done_d   = 1'b0;
    beat_end = idx_q + IW'(LANES);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_flat;
          mode_d  = mode;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Lanes falling past the last element have no matching index and write nothing.
        for (int j = 0; j < int'(N); j++) begin
          if ((IW'(j) >= idx_q) && (IW'(j) < beat_end))
            f_d[j] = apply_op(a_q[j], mode_q);
        end
        idx_d = beat_end;
        if (beat_end >= IW'(N)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation and clears f.
  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      f_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      f_q     <= f_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
